// File: rtl/scancode_pkg.sv
// Shared constants, FSM state type and ignore-list helper for the PS/2 set-2
// scan-code decoder.
package scancode_pkg;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BREAK = 8'hF0;

  localparam logic [7:0] DEF_KEY_LEFT  = 8'h6B;
  localparam logic [7:0] DEF_KEY_RIGHT = 8'h74;
  localparam logic [7:0] DEF_KEY_FIRE  = 8'h29;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BREAK,
    ST_EXT_BREAK
  } state_t;

  // Keyboard housekeeping bytes (BAT result, echo, ack, errors, resend).
  function automatic logic is_ignored(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/scancode_decoder_axis.sv
// AXI-Stream PS/2 set-2 scan-code decoder: tracks E0/F0 prefixes, reports
// make/break events and keeps held levels for left/right/fire keys.
module scancode_decoder_axis
  import scancode_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
  parameter logic [7:0]  KEY_LEFT       = DEF_KEY_LEFT,
  parameter logic [7:0]  KEY_RIGHT      = DEF_KEY_RIGHT,
  parameter logic [7:0]  KEY_FIRE       = DEF_KEY_FIRE
) (
  input  logic                  axis_aclk_i,
  input  logic                  axis_areset_i,
  input  logic                  s_axis_tvalid_i,
  output logic                  s_axis_tready_o,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
  output logic                  left_o,
  output logic                  right_o,
  output logic                  fire_o,
  output logic                  fire_pulse_o,
  output logic                  key_event_o,
  output logic [7:0]            key_code_o,
  output logic                  key_ext_o,
  output logic                  key_break_o,
  output logic                  error_o
);

  localparam int unsigned     CW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   TMO = CW'(TIMEOUT_CYCLES);

  state_t        state, nxt;
  logic [CW-1:0] cnt, cnt_inc;
  logic [7:0]    data;
  logic          accept, ev, ev_ext, ev_brk, bad, tmo;

  assign data    = s_axis_tdata_i[7:0];
  assign accept  = s_axis_tvalid_i && s_axis_tready_o;
  assign cnt_inc = (cnt == TMO) ? cnt : cnt + 1'b1;

  // An accepted byte is decoded first, so it pre-empts a timeout in the same cycle.
  always_comb begin
    nxt    = state;
    ev     = 1'b0;
    ev_ext = 1'b0;
    ev_brk = 1'b0;
    bad    = 1'b0;
    tmo    = 1'b0;
    if (accept) begin
      unique case (state)
        ST_IDLE: begin
          if (data == PFX_EXT)        nxt = ST_EXT;
          else if (data == PFX_BREAK) nxt = ST_BREAK;
          else if (!is_ignored(data)) ev  = 1'b1;
        end
        ST_EXT: begin
          if (data == PFX_BREAK)    nxt = ST_EXT_BREAK;
          else if (data == PFX_EXT) bad = 1'b1;
          else begin
            ev     = 1'b1;
            ev_ext = 1'b1;
            nxt    = ST_IDLE;
          end
        end
        ST_BREAK, ST_EXT_BREAK: begin
          nxt = ST_IDLE;
          if (data == PFX_EXT || data == PFX_BREAK) bad = 1'b1;
          else begin
            ev     = 1'b1;
            ev_brk = 1'b1;
            ev_ext = (state == ST_EXT_BREAK);
          end
        end
        default: nxt = ST_IDLE;
      endcase
    end else if (state != ST_IDLE && cnt_inc == TMO) begin
      tmo = 1'b1;
      nxt = ST_IDLE;
    end
  end

  always_ff @(posedge axis_aclk_i) begin
    if (axis_areset_i) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      s_axis_tready_o <= 1'b0;
      left_o          <= 1'b0;
      right_o         <= 1'b0;
      fire_o          <= 1'b0;
      fire_pulse_o    <= 1'b0;
      key_event_o     <= 1'b0;
      key_code_o      <= '0;
      key_ext_o       <= 1'b0;
      key_break_o     <= 1'b0;
      error_o         <= 1'b0;
    end else begin
      state           <= nxt;
      s_axis_tready_o <= 1'b1;
      key_event_o     <= ev;
      fire_pulse_o    <= 1'b0;
      error_o         <= bad | tmo;
      cnt             <= (accept || state == ST_IDLE || nxt == ST_IDLE) ? '0 : cnt_inc;
      if (ev) begin
        key_code_o  <= data;
        key_ext_o   <= ev_ext;
        key_break_o <= ev_brk;
        if (ev_ext && data == KEY_LEFT)  left_o  <= !ev_brk;
        if (ev_ext && data == KEY_RIGHT) right_o <= !ev_brk;
        if (!ev_ext && data == KEY_FIRE) begin
          fire_o       <= !ev_brk;
          fire_pulse_o <= !ev_brk && !fire_o;
        end
      end
    end
  end

endmodule

// File: tb/tb_scancode_decoder_axis.sv
// Scoreboard bench for scancode_decoder_axis: directed scenarios plus random
// byte streams checked against a prefix-rule reference model.
module tb_scancode_decoder_axis;

  localparam int unsigned TMO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] tdata = '0;
  logic       tready, left, right, fire, fire_pulse, key_event, key_ext, key_break, err;
  logic [7:0] key_code;

  scancode_decoder_axis #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(TMO)) dut (
    .axis_aclk_i(clk), .axis_areset_i(rst),
    .s_axis_tvalid_i(valid), .s_axis_tready_o(tready), .s_axis_tdata_i(tdata),
    .left_o(left), .right_o(right), .fire_o(fire), .fire_pulse_o(fire_pulse),
    .key_event_o(key_event), .key_code_o(key_code), .key_ext_o(key_ext),
    .key_break_o(key_break), .error_o(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       err;
    logic       ev;
    logic [7:0] code;
    logic       ext, brk, left, right, fire, pulse;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: pending prefix flags, idle counter and held-key set.
  bit         m_ext, m_brk;
  int         m_idle;
  bit         m_left, m_right, m_fire;
  logic [7:0] m_code;
  bit         m_cext, m_cbrk;

  function automatic exp_t snap(bit e, bit v, bit p);
    exp_t x;
    x = '{err: e, ev: v, code: m_code, ext: m_cext, brk: m_cbrk,
          left: m_left, right: m_right, fire: m_fire, pulse: p};
    return x;
  endfunction

  task automatic m_reset();
    m_ext = 0; m_brk = 0; m_idle = 0;
    m_left = 0; m_right = 0; m_fire = 0;
    m_code = '0; m_cext = 0; m_cbrk = 0;
  endtask

  task automatic m_event(logic [7:0] b, bit ext, bit brk);
    bit p;
    p = 0;
    m_code = b; m_cext = ext; m_cbrk = brk;
    if (ext && b == 8'h6B) m_left = !brk;
    if (ext && b == 8'h74) m_right = !brk;
    if (!ext && b == 8'h29) begin
      p = !brk && !m_fire;
      m_fire = !brk;
    end
    q.push_back(snap(0, 1, p));
  endtask

  task automatic m_byte(logic [7:0] b);
    bit ign;
    ign = (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFA) ||
          (b >= 8'hFC);
    m_idle = 0;
    if (m_brk) begin
      if (b == 8'hE0 || b == 8'hF0) q.push_back(snap(1, 0, 0));
      else m_event(b, m_ext, 1);
      m_ext = 0; m_brk = 0;
    end else if (m_ext) begin
      if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE0) q.push_back(snap(1, 0, 0));
      else begin
        m_event(b, 1, 0);
        m_ext = 0;
      end
    end else begin
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if (!ign) m_event(b, 0, 0);
    end
  endtask

  task automatic m_idle_cycle();
    if (m_ext || m_brk) begin
      m_idle++;
      if (m_idle == TMO) begin
        q.push_back(snap(1, 0, 0));
        m_ext = 0; m_brk = 0; m_idle = 0;
      end
    end
  endtask

  // Driver: inputs change on the falling edge, model steps for the next rising edge.
  task automatic send(logic [7:0] b);
    @(negedge clk);
    rst = 0; valid = 1; tdata = b;
    m_byte(b);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid = 0; tdata = 8'($urandom);
      m_idle_cycle();
    end
  endtask

  task automatic do_reset(int n);
    @(negedge clk);
    rst = 1; valid = 0;
    m_reset();
    idle(n - 1);
    @(negedge clk);
    rst = 0;
    m_idle_cycle();
  endtask

  task automatic seq(input logic [7:0] bs[$]);
    foreach (bs[i]) send(bs[i]);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    exp_t a, e;
    #1;
    a = '{err: err, ev: key_event, code: key_code, ext: key_ext, brk: key_break,
          left: left, right: right, fire: fire, pulse: fire_pulse};
    checks++;
    if (rst) begin
      if (tready !== 1'b0 || a !== '0) begin
        errors++;
        $display("FAIL reset_state: tready=%b outputs=%h, required tready=0 outputs=0", tready, a);
      end
    end else begin
      if (tready !== 1'b1) begin
        errors++;
        $display("FAIL tready: got %b, required 1", tready);
      end
      if (key_event || err) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got %h, required nothing", a);
        end else begin
          e = q.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL event: got err=%b ev=%b code=%h ext=%b brk=%b L=%b R=%b F=%b P=%b, required err=%b ev=%b code=%h ext=%b brk=%b L=%b R=%b F=%b P=%b",
                     a.err, a.ev, a.code, a.ext, a.brk, a.left, a.right, a.fire, a.pulse,
                     e.err, e.ev, e.code, e.ext, e.brk, e.left, e.right, e.fire, e.pulse);
          end
        end
      end else if (fire_pulse) begin
        checks++; errors++;
        $display("FAIL stray_pulse: fire_pulse_o=1 without key_event_o");
      end
    end
  end

  logic [7:0] ignore_list [8] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};

  initial begin
    logic [7:0] b;
    int r;
    m_reset();
    do_reset(3);

    seq('{8'h29}); idle(2);
    seq('{8'hF0, 8'h29}); idle(2);
    seq('{8'h29, 8'h29, 8'h29}); idle(1);
    seq('{8'hF0, 8'h29}); idle(1);
    seq('{8'hE0, 8'h6B, 8'hE0, 8'h74}); idle(1);
    seq('{8'hE0, 8'hF0, 8'h6B}); idle(1);
    seq('{8'h6B, 8'hFA, 8'hAA}); idle(2);
    seq('{8'hF0, 8'hF0}); idle(2);
    seq('{8'hE0}); idle(TMO); idle(2);
    seq('{8'hE0}); idle(TMO - 1); seq('{8'h74}); idle(2);
    seq('{8'hE0}); idle(TMO - 1); seq('{8'hF0}); idle(TMO); idle(2);
    seq('{8'hE0, 8'hE0, 8'h74}); idle(2);
    seq('{8'hE0}); do_reset(2); seq('{8'h74}); idle(2);

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    b = 8'hE0;
        2:       b = 8'hF0;
        3:       b = 8'h29;
        4:       b = 8'h6B;
        5:       b = 8'h74;
        6:       b = ignore_list[$urandom_range(0, 7)];
        default: b = 8'($urandom);
      endcase
      send(b);
      r = $urandom_range(0, 19);
      if (r == 0)      idle($urandom_range(TMO - 2, TMO + 2));
      else if (r == 1) do_reset($urandom_range(1, 3));
      else if (r < 8)  idle($urandom_range(1, 3));
    end
    idle(TMO + 4);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected outputs never appeared, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
